// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - pipeline hazard controller: load-use, mul/div wait, memory wait and branch redirect
module hazard_unit #(
    parameter int REDIRECT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_rs1_en,
    input  logic        id_rs2_en,
    input  logic [4:0]  ex_rd,
    input  logic        ex_load,
    input  logic        ex_branch_taken,
    input  logic        ex_md_start,
    input  logic        md_done,
    input  logic        mem_req,
    input  logic        mem_ack,
    output logic        stall_if,
    output logic        stall_id,
    output logic        stall_ex,
    output logic        stall_mem,
    output logic        flush_id,
    output logic        flush_ex,
    output logic        flush_mem,
    output logic        flush_wb,
    output logic [15:0] stall_count
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MD_WAIT  = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] stall_count_q;

    logic mem_stall;
    logic load_use;

    assign mem_stall = mem_req && !mem_ack;
    assign load_use  = ex_load && (ex_rd != 5'd0) &&
                       ((id_rs1_en && (id_rs1 == ex_rd)) ||
                        (id_rs2_en && (id_rs2 == ex_rd)));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        stall_ex  = 1'b0;
        stall_mem = 1'b0;
        flush_id  = 1'b0;
        flush_ex  = 1'b0;
        flush_mem = 1'b0;
        flush_wb  = 1'b0;

        // A pending memory access freezes everything, including the FSM.
        if (mem_stall) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            stall_ex  = 1'b1;
            stall_mem = 1'b1;
            flush_wb  = 1'b1;
        end else begin
            case (state_q)
                RUN: begin
                    if (ex_branch_taken) begin
                        flush_id = 1'b1;
                        flush_ex = 1'b1;
                        if (REDIRECT_CYCLES > 1) begin
                            state_d = REDIRECT;
                            cnt_d   = 4'(REDIRECT_CYCLES - 1);
                        end
                    end else if (ex_md_start) begin
                        stall_if  = 1'b1;
                        stall_id  = 1'b1;
                        stall_ex  = 1'b1;
                        flush_mem = 1'b1;
                        if (!md_done) begin
                            state_d = MD_WAIT;
                        end
                    end else if (load_use) begin
                        stall_if = 1'b1;
                        stall_id = 1'b1;
                        flush_ex = 1'b1;
                    end
                end
                MD_WAIT: begin
                    if (md_done) begin
                        state_d = RUN;
                    end else begin
                        stall_if  = 1'b1;
                        stall_id  = 1'b1;
                        stall_ex  = 1'b1;
                        flush_mem = 1'b1;
                    end
                end
                REDIRECT: begin
                    flush_id = 1'b1;
                    cnt_d    = cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = RUN;
                    cnt_d   = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= RUN;
            cnt_q         <= 4'd0;
            stall_count_q <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (stall_if && (stall_count_q != 16'hFFFF)) begin
                stall_count_q <= stall_count_q + 16'd1;
            end
        end
    end

    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - self-checking bench for hazard_unit against a behavioural model
module tb_hazard_unit;

    localparam int RC = 3;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_rs1_en, id_rs2_en, ex_load, ex_branch_taken;
    logic        ex_md_start, md_done, mem_req, mem_ack;
    logic        stall_if, stall_id, stall_ex, stall_mem;
    logic        flush_id, flush_ex, flush_mem, flush_wb;
    logic [15:0] stall_count;

    always #5 clk = ~clk;

    hazard_unit #(.REDIRECT_CYCLES(RC)) dut (
        .clk(clk), .reset_n(reset_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_en(id_rs1_en), .id_rs2_en(id_rs2_en),
        .ex_rd(ex_rd), .ex_load(ex_load), .ex_branch_taken(ex_branch_taken),
        .ex_md_start(ex_md_start), .md_done(md_done), .mem_req(mem_req), .mem_ack(mem_ack),
        .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .stall_mem(stall_mem),
        .flush_id(flush_id), .flush_ex(flush_ex), .flush_mem(flush_mem), .flush_wb(flush_wb),
        .stall_count(stall_count)
    );

    // {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, flush_mem, flush_wb}
    wire [7:0] outs = {stall_if, stall_id, stall_ex, stall_mem,
                       flush_id, flush_ex, flush_mem, flush_wb};

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model: "busy with mul/div", "flush-only cycles still owed", stall total.
    bit       m_md;
    int       m_redir;
    int       m_cnt;
    bit       n_md;
    int       n_redir;
    logic [7:0] m_exp;

    task automatic model_reset();
        m_md = 0; m_redir = 0; m_cnt = 0;
    endtask

    task automatic model_eval();
        bit lu;
        lu = ex_load && ex_rd != 0 &&
             ((id_rs1_en && id_rs1 == ex_rd) || (id_rs2_en && id_rs2 == ex_rd));
        n_md = m_md;
        n_redir = m_redir;
        m_exp = 8'h00;
        if (mem_req && !mem_ack) begin
            m_exp = 8'hF1;
        end else if (m_md) begin
            if (md_done) n_md = 0;
            else m_exp = 8'hE2;
        end else if (m_redir > 0) begin
            m_exp = 8'h08;
            n_redir = m_redir - 1;
        end else if (ex_branch_taken) begin
            m_exp = 8'h0C;
            n_redir = RC - 1;
        end else if (ex_md_start) begin
            m_exp = 8'hE2;
            n_md = !md_done;
        end else if (lu) begin
            m_exp = 8'hC4;
        end
    endtask

    task automatic step(input string tag, input int want);
        @(negedge clk);
        model_eval();
        check({tag, "_outs"}, 32'(outs), 32'(m_exp));
        check({tag, "_cnt"}, 32'(stall_count), 32'(m_cnt));
        if (want >= 0) check({tag, "_const"}, 32'(outs), 32'(want));
        @(posedge clk);
        m_md = n_md;
        m_redir = n_redir;
        if (m_exp[7] && m_cnt < 65535) m_cnt++;
        #1;
    endtask

    task automatic clear_inputs();
        id_rs1 = 0; id_rs2 = 0; id_rs1_en = 0; id_rs2_en = 0;
        ex_rd = 0; ex_load = 0; ex_branch_taken = 0;
        ex_md_start = 0; md_done = 0; mem_req = 0; mem_ack = 0;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset_n = 1'b0;
        clear_inputs();
        #1;
        check({tag, "_rst_outs"}, 32'(outs), 32'h0);
        check({tag, "_rst_cnt"}, 32'(stall_count), 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        clear_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_outs", 32'(outs), 32'h0);
        check("reset_cnt", 32'(stall_count), 32'h0);
        reset_n = 1'b1;
        step("idle", 0);

        // load-use, and the x0 exemption
        ex_load = 1; ex_rd = 5; id_rs1 = 5; id_rs1_en = 1;
        step("lu", 8'hC4);
        clear_inputs();
        step("lu_after", 0);
        ex_load = 1; ex_rd = 0; id_rs1 = 0; id_rs1_en = 1;
        step("lu_x0", 0);
        clear_inputs();

        // memory wait: three stalled cycles, released on ack
        do_reset("mem");
        mem_req = 1;
        repeat (3) step("mem_wait", 8'hF1);
        mem_ack = 1;
        step("mem_ack", 0);
        check("mem_stall_count", 32'(stall_count), 32'd3);
        clear_inputs();

        // branch redirect
        ex_branch_taken = 1;
        step("br0", 8'h0C);
        ex_branch_taken = 0;
        step("br1", 8'h08);
        step("br2", 8'h08);
        step("br3", 0);

        // branch wins over load-use; memory stall defers the branch
        ex_branch_taken = 1; ex_load = 1; ex_rd = 7; id_rs2 = 7; id_rs2_en = 1;
        step("br_lu", 8'h0C);
        clear_inputs();
        step("br_lu_r1", 8'h08);
        step("br_lu_r2", 8'h08);
        ex_branch_taken = 1; ex_load = 1; ex_rd = 7; id_rs2 = 7; id_rs2_en = 1;
        mem_req = 1;
        step("br_mem0", 8'hF1);
        step("br_mem1", 8'hF1);
        mem_ack = 1;
        step("br_mem_ack", 8'h0C);
        clear_inputs();
        step("br_mem_r1", 8'h08);
        step("br_mem_r2", 8'h08);
        step("br_mem_end", 0);

        // mul/div wait of four stalled cycles
        ex_md_start = 1;
        step("md0", 8'hE2);
        ex_md_start = 0;
        step("md1", 8'hE2);
        step("md2", 8'hE2);
        step("md3", 8'hE2);
        md_done = 1;
        step("md_done", 0);
        clear_inputs();
        step("md_idle", 0);

        // asynchronous reset in the middle of a mul/div wait
        ex_md_start = 1;
        step("mdr0", 8'hE2);
        ex_md_start = 0;
        step("mdr1", 8'hE2);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("mdr_rst_outs", 32'(outs), 32'h0);
        check("mdr_rst_cnt", 32'(stall_count), 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        step("mdr_post", 0);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            id_rs1 = 5'($urandom_range(0, 3));
            id_rs2 = 5'($urandom_range(0, 3));
            ex_rd = 5'($urandom_range(0, 3));
            id_rs1_en = 1'($urandom_range(0, 1));
            id_rs2_en = 1'($urandom_range(0, 1));
            ex_load = 1'($urandom_range(0, 1));
            ex_branch_taken = ($urandom_range(0, 7) == 0);
            ex_md_start = ($urandom_range(0, 5) == 0);
            md_done = ($urandom_range(0, 2) == 0);
            mem_req = ($urandom_range(0, 3) == 0);
            mem_ack = 1'($urandom_range(0, 1));
            step("rand", -1);
        end
        clear_inputs();

        // saturation of the stall counter
        do_reset("sat");
        mem_req = 1;
        repeat (70000) step("sat", -1);
        check("sat_value", 32'(stall_count), 32'hFFFF);
        repeat (5) step("sat_hold", 8'hF1);
        check("sat_held", 32'(stall_count), 32'hFFFF);
        clear_inputs();
        step("sat_end", 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
